// File: rtl/btn_sw_in_periph.sv
// Switch/button input peripheral: 2-FF synchronizers, tick-based debounce,
// sticky press/release events and a four-register CPU slave with level IRQ.
`timescale 1ns/1ps
module btn_sw_in_periph #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned SW_W            = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [SW_W-1:0] sw_i,
  input  logic [3:0]      btn_i,
  input  logic            sel_i,
  input  logic            we_i,
  input  logic [1:0]      addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            irq_o
);

  localparam int unsigned IN_W  = SW_W + 4;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_SW  = 2'd0;
  localparam logic [1:0] ADDR_BTN = 2'd1;
  localparam logic [1:0] ADDR_EVT = 2'd2;
  localparam logic [1:0] ADDR_IEN = 2'd3;

  logic [IN_W-1:0]  raw_in;
  logic [IN_W-1:0]  sync1_q, sync2_q;
  logic [IN_W-1:0]  samp_q, samp_d;
  logic [IN_W-1:0]  deb_q, deb_d;
  logic [IN_W-1:0]  agree;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [3:0]       btn_prev_q;
  logic [3:0]       deb_btn;
  logic [SW_W-1:0]  deb_sw;
  logic [7:0]       evt_q, evt_d, evt_set, evt_clr;
  logic [7:0]       ien_q, ien_d;
  logic [31:0]      rdata_d;
  logic             irq_d;
  logic             wr_en;
  logic             unused_wdata;

  assign raw_in       = {btn_i, sw_i};
  assign unused_wdata = ^wdata_i[31:8];

  assign tick  = (cnt_q == CNT_MAX);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  // A bit is accepted only when two consecutive ticks saw the same value.
  assign agree  = ~(sync2_q ^ samp_q);
  assign samp_d = tick ? sync2_q : samp_q;
  assign deb_d  = tick ? ((deb_q & ~agree) | (sync2_q & agree)) : deb_q;

  assign deb_btn = deb_q[IN_W-1 -: 4];
  assign deb_sw  = deb_q[SW_W-1:0];

  assign wr_en   = sel_i & we_i;
  assign evt_set = {btn_prev_q & ~deb_btn, deb_btn & ~btn_prev_q};
  assign evt_clr = (wr_en && addr_i == ADDR_EVT) ? wdata_i[7:0] : 8'h00;
  // Set is OR-ed after the clear so a same-cycle new event survives W1C.
  assign evt_d   = (evt_q & ~evt_clr) | evt_set;
  assign ien_d   = (wr_en && addr_i == ADDR_IEN) ? wdata_i[7:0] : ien_q;
  assign irq_d   = |(evt_q & ien_q);

  always_comb begin
    rdata_d = rdata_o;
    if (sel_i && !we_i) begin
      unique case (addr_i)
        ADDR_SW:  rdata_d = 32'(deb_sw);
        ADDR_BTN: rdata_d = {28'b0, deb_btn};
        ADDR_EVT: rdata_d = {24'b0, evt_q};
        ADDR_IEN: rdata_d = {24'b0, ien_q};
        default:  rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      samp_q     <= '0;
      deb_q      <= '0;
      cnt_q      <= '0;
      btn_prev_q <= '0;
      evt_q      <= '0;
      ien_q      <= '0;
      rdata_o    <= '0;
      irq_o      <= 1'b0;
    end else begin
      sync1_q    <= raw_in;
      sync2_q    <= sync1_q;
      samp_q     <= samp_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= deb_btn;
      evt_q      <= evt_d;
      ien_q      <= ien_d;
      rdata_o    <= rdata_d;
      irq_o      <= irq_d;
    end
  end

endmodule

// File: tb/tb_btn_sw_in_periph.sv
// Scoreboard bench for btn_sw_in_periph with a 4-clock debounce tick.
`timescale 1ns/1ps
module tb_btn_sw_in_periph;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] sw_i;
  logic [3:0]  btn_i;
  logic        sel_i, we_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        irq_o;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc;
  logic    rd_pend;

  btn_sw_in_periph #(.DEBOUNCE_CYCLES(4), .SW_W(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sw_i(sw_i), .btn_i(btn_i),
    .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Edge count since reset release; debounce ticks land on multiples of 4.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_pend <= 1'b0;
    else         rd_pend <= sel_i && !we_i;
  end

  always @(negedge clk_i) begin
    if (rd_pend) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        $display("rd %s data %h", e.tag, rdata_o);
        check(e.tag, rdata_o, e.exp);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_phase(input int p);
    do begin
      @(posedge clk_i);
      #1;
    end while ((cyc % 4) != p);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    rd_exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    sel_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = a;
    @(posedge clk_i);
    #1;
    sel_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    $display("wr addr %0d data %h", a, d);
    sel_i   = 1'b1;
    we_i    = 1'b1;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk_i);
    #1;
    sel_i = 1'b0;
    we_i  = 1'b0;
  endtask

  initial begin
    sw_i = 16'hFFFF; btn_i = 4'hF;
    sel_i = 1'b0; we_i = 1'b0; addr_i = 2'd0; wdata_i = 32'h0;
    rst_ni = 1'b0;
    wait_cyc(3);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_cyc(12);
    rd(2'd0, 32'h0000_FFFF, "rst_sw");
    rd(2'd1, 32'h0000_000F, "rst_btn");
    rd(2'd2, 32'h0000_000F, "rst_evt");

    // Release all buttons; new switch pattern.
    btn_i = 4'h0; sw_i = 16'hA5C3;
    wait_cyc(16);
    rd(2'd0, 32'h0000_A5C3, "sw_pattern");
    rd(2'd1, 32'h0, "btn_released");
    rd(2'd2, 32'h0000_00FF, "evt_release");
    wr(2'd2, 32'hFF);
    rd(2'd2, 32'h0, "evt_cleared");

    // Three-clock glitch must be rejected.
    wait_cyc(2);
    btn_i[0] = 1'b1;
    wait_cyc(3);
    btn_i[0] = 1'b0;
    wait_cyc(12);
    rd(2'd1, 32'h0, "glitch_btn");
    rd(2'd2, 32'h0, "glitch_evt");

    // Held press, aligned so the first tick sees it 3 edges later.
    wait_phase(1);
    btn_i[0] = 1'b1;
    wait_cyc(6);
    rd(2'd1, 32'h0, "deb_early");
    rd(2'd1, 32'h1, "deb_btn");
    rd(2'd2, 32'h1, "deb_evt");
    btn_i[0] = 1'b0;
    wait_cyc(16);
    rd(2'd2, 32'h11, "deb_rel_evt");
    wr(2'd2, 32'hFF);

    // Press/release button 2 then W1C one bit at a time.
    btn_i[2] = 1'b1;
    wait_cyc(16);
    btn_i[2] = 1'b0;
    wait_cyc(16);
    rd(2'd2, 32'h44, "evt_b2");
    wr(2'd2, 32'h04);
    rd(2'd2, 32'h40, "w1c_press");
    wr(2'd2, 32'h40);
    rd(2'd2, 32'h0, "w1c_release");

    // W1C lands on the same edge the press event sets.
    wait_phase(1);
    btn_i[1] = 1'b1;
    wait_cyc(7);
    wr(2'd2, 32'h02);
    rd(2'd2, 32'h02, "collide_evt");
    btn_i[1] = 1'b0;
    wait_cyc(16);
    wr(2'd2, 32'hFF);
    rd(2'd2, 32'h0, "collide_clr");

    // Interrupt path.
    wr(2'd3, 32'h01);
    wait_phase(1);
    btn_i[0] = 1'b1;
    wait_cyc(8);
    check("irq_pre", 32'(irq_o), 32'h0);
    wait_cyc(1);
    check("irq_set", 32'(irq_o), 32'h1);
    wr(2'd2, 32'h01);
    check("irq_hold", 32'(irq_o), 32'h1);
    wait_cyc(1);
    check("irq_w1c", 32'(irq_o), 32'h0);
    btn_i[0] = 1'b0;
    wait_cyc(16);
    check("irq_masked", 32'(irq_o), 32'h0);
    wr(2'd3, 32'h10);
    check("irq_ien_pre", 32'(irq_o), 32'h0);
    wait_cyc(1);
    check("irq_ien_on", 32'(irq_o), 32'h1);
    wr(2'd3, 32'h00);
    check("irq_ien_hold", 32'(irq_o), 32'h1);
    wait_cyc(1);
    check("irq_ien_off", 32'(irq_o), 32'h0);
    wait_cyc(4);
    check("irq_stays_off", 32'(irq_o), 32'h0);
    wr(2'd2, 32'hFF);

    // Bus: read-only writes ignored, back-to-back reads.
    wr(2'd0, 32'hDEAD_BEEF);
    wr(2'd1, 32'hDEAD_BEEF);
    btn_i[3] = 1'b1;
    wait_cyc(16);
    wr(2'd3, 32'hFFFF_FF5A);
    rd(2'd0, 32'h0000_A5C3, "b2b_sw");
    rd(2'd1, 32'h8, "b2b_btn");
    rd(2'd2, 32'h08, "b2b_evt");
    rd(2'd3, 32'h5A, "b2b_ien");
    wait_cyc(2);
    check("bus_irq", 32'(irq_o), 32'h1);

    // Async reset in the middle of an IEN write.
    sel_i = 1'b1; we_i = 1'b1; addr_i = 2'd3; wdata_i = 32'hFF;
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_rdata", rdata_o, 32'h0);
    check("arst_irq", 32'(irq_o), 32'h0);
    sel_i = 1'b0; we_i = 1'b0;
    wait_cyc(2);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_cyc(12);
    rd(2'd1, 32'h8, "arst_btn");
    rd(2'd2, 32'h08, "arst_evt");
    rd(2'd3, 32'h0, "arst_ien");
    rd(2'd0, 32'h0000_A5C3, "arst_sw");
    wait_cyc(2);
    check("arst_irq_after", 32'(irq_o), 32'h0);

    wait_cyc(4);
    if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_sw_in_periph.md
# btn_sw_in_periph

CPU-readable input peripheral for the Basys3 CPU: takes the raw board switches and the four buttons, synchronizes and debounces them, and exposes their levels plus sticky press/release events to the CPU through a small memory-mapped register slave. It is the input-side counterpart of the LED/7-seg output peripherals and sits between the board pins and the CPU data bus inside the 10 MHz CPU domain. An optional level interrupt lets the CPU stop polling buttons.

## Interface
- DEBOUNCE_CYCLES, 100000, clocks between debounce sample ticks (10 ms at 10 MHz); legal range 2..2^24.
- SW_W, 16, number of switch inputs.
- clk_i  input  1  CPU clock (10 MHz); all logic on rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- sw_i  input  SW_W  raw switches, asynchronous to clk_i.
- btn_i  input  4  raw buttons {b3,b2,b1,b0}, asynchronous, active-high.
- sel_i  input  1  bus access strobe, one cycle per access.
- we_i  input  1  1 = write, 0 = read; sampled with sel_i.
- addr_i  input  2  word register index.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data, registered.
- irq_o  output  1  level interrupt, registered.

## Operation
- Synchronizer: every input bit passes a 2-FF synchronizer (reset 0).
- Tick: counter 0..DEBOUNCE_CYCLES-1; tick pulse when counter = DEBOUNCE_CYCLES-1, then wraps to 0. Counter reset 0.
- Debounce (shared tick, per bit): on tick, samp_q <= sync; if sync == samp_q (before update) then deb <= sync. A change is accepted after two consecutive agreeing ticks; a glitch seen on only one tick is rejected.
- Events: per button, deb 0->1 sets EVT[i] (press), deb 1->0 sets EVT[4+i] (release). Bits sticky until cleared.
- Register map (addr_i):
  - 0 SW: rdata = {zero, deb_sw[SW_W-1:0]}; read-only.
  - 1 BTN: rdata = {28'b0, deb_btn}; read-only.
  - 2 EVT: rdata = {24'b0, evt[7:0]}; write-1-to-clear using wdata_i[7:0].
  - 3 IEN: rdata = {24'b0, ien[7:0]}; read/write wdata_i[7:0].
- Writes to addresses 0 and 1 are ignored; upper wdata bits ignored.
- Reads are side-effect free (EVT not cleared by read).
- irq_o <= |(evt & ien), registered.

## Timing
- Reset values: rdata_o = 0, irq_o = 0, evt = 0, ien = 0, deb = 0, samp_q = 0, tick counter = 0.
- Read latency 1: rdata_o valid the cycle after sel_i=1, we_i=0; rdata_o holds its last value otherwise.
- Read returns register contents as of the sel_i cycle (pre-write/pre-event state).
- Write takes effect at the sel_i edge; visible to a read issued the next cycle.
- Input-to-deb latency: 2 sync cycles + between 1 and 2 tick periods (deb updates on the second agreeing tick).
- Event set: EVT bit set the cycle after deb changes; irq_o asserts one cycle after that (if enabled).
- Simultaneous event set and W1C clear of the same bit: set wins (bit stays 1). Clear of other bits proceeds.
- Writing IEN with a pending EVT bit: irq_o follows one cycle later; clearing IEN drops irq_o one cycle later.
- Async reset mid-debounce or mid-access: all state returns to reset values immediately; no partial write survives; after release, pins already high become deb=1 after the normal latency and generate press events.

## Test plan
(DEBOUNCE_CYCLES = 4 for all scenarios.)
- Reset: hold rst_ni=0 with sw_i=16'hFFFF, btn_i=4'hF -> rdata_o=0, irq_o=0; release, wait 12 clocks, read addr 0 -> 32'h0000_FFFF, addr 2 -> 32'h0000_000F.
- Debounce: btn_i[0] high for 3 clocks then low -> BTN reads 0, EVT reads 0; hold high 12 clocks -> BTN = 1 and EVT[0]=1 within 2+8 clocks of the edge.
- Events/W1C: press and release btn 2 -> EVT = 8'h44; write EVT 8'h04 -> read 8'h40; write 8'h40 -> read 0.
- Set-vs-clear collision: issue W1C of EVT[1] in the exact cycle press event 1 sets -> EVT[1] reads 1.
- Interrupt: IEN=8'h01, press btn 0 -> irq_o=1 one cycle after EVT[0] sets; W1C EVT[0] -> irq_o=0 next cycle; IEN=0 with EVT pending -> irq_o stays 0.
- Bus: write 32'hDEAD_BEEF to addr 0 -> SW unchanged; back-to-back reads addr 0,1,2,3 on consecutive cycles -> each rdata_o one cycle after its sel_i, correct per address.
